muldiv_unit: RTL and testbench

Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU with a start/busy/done handshake and supports MTHI/MTLO writes. It sits beside the execute stage; the hazard unit stalls MFHI/MFLO while busy=1. It generalises the fixed 32-bit two-stage multiplier with WIDTH, MUL_STAGES, signed/unsigned modes, an iterative divider and cancel.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Pipelined multiplier, iterative restoring divider, cancel, MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] pipe_q [MUL_STAGES];
  logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dz_q, qneg_q, rneg_q;
  logic               done_q;

  logic               accept, wr_mul, wr_fix;
  logic               sa, sb, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   q_fin, r_fin;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign sa     = op[0] & a[WIDTH-1];
  assign sb     = op[0] & b[WIDTH-1];
  assign b_zero = (b == '0);
  assign a_mag  = sa ? -a : a;
  assign b_mag  = sb ? -b : b;
  assign a_ext  = {{WIDTH{sa}}, a};
  assign b_ext  = {{WIDTH{sb}}, b};
  assign prod   = a_ext * b_ext;

  // One restoring step: shift in next dividend bit, trial subtract.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  assign q_fin = qneg_q ? -quo_q : quo_q;
  assign r_fin = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wr_mul  = 1'b0;
    wr_fix  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          unique case (1'b1)
            !op[1]:  state_d = MUL;
            b_zero:  state_d = FIX;
            default: state_d = DIV;
          endcase
        end
      end
      MUL: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(MUL_STAGES)) begin
          wr_mul  = 1'b1;
          state_d = IDLE;
        end
      end
      DIV: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        wr_fix  = !cancel;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      dz_q   <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= wr_mul | wr_fix;
      for (int i = 1; i < MUL_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
      if (accept) begin
        pipe_q[0] <= prod;
        cnt_q     <= op[1] ? '0 : CW'(1);
        // Divide by zero parks the raw dividend for the HI write.
        quo_q     <= b_zero ? a : a_mag;
        rem_q     <= '0;
        dvs_q     <= b_mag;
        dz_q      <= b_zero;
        qneg_q    <= sa ^ sb;
        rneg_q    <= sa;
      end else if (state_q == MUL) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == DIV) begin
        cnt_q <= cnt_q + 1'b1;
        rem_q <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], !diff[WIDTH]};
      end
      if (wr_mul) begin
        {hi_q, lo_q} <= pipe_q[MUL_STAGES-1];
      end else if (wr_fix) begin
        hi_q <= dz_q ? quo_q : r_fin;
        lo_q <= dz_q ? '1 : q_fin;
      end else if (!busy) begin
        if (we_hi) hi_q <= wd;
        if (we_lo) lo_q <= wd;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// WIDTH=32, MUL_STAGES=2; inputs change and outputs are sampled on negedge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        we_hi = 1'b0;
  logic        we_lo = 1'b0;
  logic [31:0] wd = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Leaves start=1 so the next posedge is T0.
  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b want all 0",
               hi, lo, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL multu_t0: busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL multu_t1: busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || busy !== 1'b0 ||
        done !== 1'b1) begin
      n_bad++;
      $display("FAIL multu_res: hi=%h lo=%h busy=%b done=%b want fffffffe 00000001 0 1",
               hi, lo, busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL multu_done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back;
    issue(2'b01, 32'hFFFFFFFD, 32'd7);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || done !== 1'b1) begin
      n_bad++;
      $display("FAIL mult_res: hi=%h lo=%h done=%b want ffffffff ffffffeb 1",
               hi, lo, done);
    end
    start = 1'b1; op = 2'b00; a = 32'h10000; b = 32'h10000;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'h1 || lo !== 32'h0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_res: hi=%h lo=%h done=%b want 00000001 00000000 1",
               hi, lo, done);
    end
  endtask

  task automatic run_div(input string nm, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, x, y);
    @(negedge clk); start = 1'b0;
    repeat (32) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy33: busy=%b done=%b want 1 0", nm, busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if (hi !== ehi || lo !== elo || busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_res: hi=%h lo=%h busy=%b done=%b want %h %h 0 1",
               nm, hi, lo, busy, done, ehi, elo);
    end
  endtask

  task automatic test_div;
    run_div("div_neg7_2", 2'b11, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
    run_div("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000);
    run_div("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("div_7_neg2", 2'b11, 32'd7, 32'hFFFFFFFE,
            32'd1, 32'hFFFFFFFD);
  endtask

  task automatic test_div_zero;
    issue(2'b10, 32'd100, 32'd0);
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL divz_busy: busy=%b want 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'h64 || lo !== 32'hFFFFFFFF || busy !== 1'b0 ||
        done !== 1'b1) begin
      n_bad++;
      $display("FAIL divz_res: hi=%h lo=%h busy=%b done=%b want 00000064 ffffffff 0 1",
               hi, lo, busy, done);
    end
  endtask

  task automatic test_cancel;
    int seen_done;
    @(negedge clk);
    we_hi = 1'b1; we_lo = 1'b1; wd = 32'h5;
    @(negedge clk);
    we_hi = 1'b0; we_lo = 1'b0;
    n_cmp++;
    if (hi !== 32'h5 || lo !== 32'h5) begin
      n_bad++; $display("FAIL mt_both: hi=%h lo=%h want 5 5", hi, lo);
    end
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    we_hi = 1'b1; wd = 32'h99;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || hi !== 32'h5) begin
      n_bad++;
      $display("FAIL ignore_busy: busy=%b hi=%h want 1 00000005", busy, hi);
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'h5 || lo !== 32'h5 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel: busy=%b hi=%h lo=%h done=%b want 0 5 5 0",
               busy, hi, lo, done);
    end
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0 || hi !== 32'h5 || lo !== 32'h5) begin
      n_bad++;
      $display("FAIL cancel_quiet: activity=%0d hi=%h lo=%h want 0 5 5",
               seen_done, hi, lo);
    end
    we_hi = 1'b1; wd = 32'hABCD;
    @(negedge clk);
    we_hi = 1'b0;
    n_cmp++;
    if (hi !== 32'hABCD || lo !== 32'h5) begin
      n_bad++;
      $display("FAIL mthi: hi=%h lo=%h want 0000abcd 00000005", hi, lo);
    end
  endtask

  task automatic test_async_reset;
    issue(2'b01, 32'd5, 32'd6);
    @(negedge clk); start = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      n_bad++;
      $display("FAIL async_rst: hi=%h lo=%h busy=%b done=%b want all 0",
               hi, lo, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(2'b00, 32'd3, 32'd4);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd12 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL post_rst_mul: hi=%h lo=%h done=%b want 0 0000000c 1",
               hi, lo, done);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_cancel();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
